// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-in/parallel-out receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } sipo_state_t;

  // Counter must be able to hold WIDTH itself.
  function automatic int sipo_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// Output holding register: loads completed words, does valid/ready, flags overrun.
module sipo_out_stage
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] parallel_o,
  output logic             valid_o,
  output logic             overrun_o
);

  always_ff @(posedge clk) begin
    if (reset) begin
      parallel_o <= '0;
      valid_o    <= 1'b0;
      overrun_o  <= 1'b0;
    end else if (load_i) begin
      // A word leaving on this edge frees the slot for the incoming one.
      if (!valid_o || ready_i) begin
        parallel_o <= word_i;
        valid_o    <= 1'b1;
      end else begin
        overrun_o  <= 1'b1;
      end
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// LSB-first serial receiver assembling WIDTH-bit words.
// Optional even-parity bit per frame with SIPO_PARITY_CHECK_EN.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] parallel_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             parity_err_o
);

  localparam int CW = sipo_cnt_w(WIDTH);

  sipo_state_t      state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic             load;
`ifdef SIPO_PARITY_CHECK_EN
  logic             perr, perr_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sr    <= sr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    load    = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
    perr    = 1'b0;
`endif
    case (state)
      IDLE: if (valid_i) begin
        sr_n    = {serial_i, sr[WIDTH-1:1]};
        cnt_n   = CW'(1);
        state_n = SHIFT;
      end
      SHIFT: if (valid_i) begin
        sr_n  = {serial_i, sr[WIDTH-1:1]};
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_CHECK_EN
          state_n = PARITY;
`else
          load    = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
`endif
        end
      end
`ifdef SIPO_PARITY_CHECK_EN
      PARITY: if (valid_i) begin
        if (serial_i == ^sr) load = 1'b1;
        else                 perr = 1'b1;
        cnt_n   = '0;
        state_n = IDLE;
      end
`endif
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy_o = (state != IDLE);

`ifdef SIPO_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= perr;
  end
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  // sr_n equals sr in PARITY, so it is the completed word in both builds.
  sipo_out_stage #(.WIDTH(WIDTH)) u_out (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .word_i    (sr_n),
    .ready_i   (ready_i),
    .parallel_o(parallel_o),
    .valid_o   (valid_o),
    .overrun_o (overrun_o)
  );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (WIDTH=4); parity steps follow SIPO_PARITY_CHECK_EN.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_i;
  logic       valid_i;
  logic [3:0] parallel_o;
  logic       valid_o;
  logic       ready_i;
  logic       busy_o;
  logic       overrun_o;
  logic       parity_err_o;

  int nchk = 0;
  int nerr = 0;

  sipo_deserializer #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_i    (serial_i),
    .valid_i     (valid_i),
    .parallel_o  (parallel_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs for one cycle; returns on the falling edge after they were sampled.
  task automatic cyc(input logic v, input logic b);
    valid_i  = v;
    serial_i = b;
    @(negedge clk);
  endtask

  // Send a word LSB first; ready_i takes rdy_last on the frame's final bit.
  task automatic send_word(input logic [3:0] w, input logic rdy_last);
    for (int i = 0; i < 4; i++) begin
`ifndef SIPO_PARITY_CHECK_EN
      if (i == 3) ready_i = rdy_last;
`endif
      cyc(1'b1, w[i]);
    end
`ifdef SIPO_PARITY_CHECK_EN
    ready_i = rdy_last;
    cyc(1'b1, ^w);
`endif
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; serial_i = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    cyc(1'b0, 1'b0);
    chk("rst_par",  parallel_o,   4'h0);
    chk("rst_vld",  valid_o,      1'b0);
    chk("rst_busy", busy_o,       1'b0);
    chk("rst_ovr",  overrun_o,    1'b0);
    chk("rst_perr", parity_err_o, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 1'b0);

    // Single word 1,0,1,1 -> D, valid for exactly one cycle
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    chk("w1_busy_mid", busy_o, 1'b1);
    cyc(1'b1, 1'b1);
`ifdef SIPO_PARITY_CHECK_EN
    chk("w1_vld_pre_par", valid_o, 1'b0);
    cyc(1'b1, 1'b1);
`endif
    chk("w1_par",  parallel_o, 4'hD);
    chk("w1_vld",  valid_o,    1'b1);
    chk("w1_busy", busy_o,     1'b0);
    cyc(1'b0, 1'b0);
    chk("w1_vld_drop", valid_o,    1'b0);
    chk("w1_par_hold", parallel_o, 4'hD);

    // Gapped bits 0,1,1,0 with three idle cycles between -> 6
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1);
    chk("gap_busy", busy_o, 1'b1);
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
    chk("gap_busy2", busy_o,  1'b1);
    chk("gap_vld0",  valid_o, 1'b0);
    cyc(1'b1, 1'b0);
`ifdef SIPO_PARITY_CHECK_EN
    cyc(1'b1, 1'b0);
`endif
    chk("gap_par",  parallel_o, 4'h6);
    chk("gap_vld",  valid_o,    1'b1);
    chk("gap_busy_end", busy_o, 1'b0);
    cyc(1'b0, 1'b0);

    // Backpressure: A then 5 with ready low -> A held, overrun set
    ready_i = 1'b0;
    send_word(4'hA, 1'b0);
    chk("bp_par1", parallel_o, 4'hA);
    chk("bp_ovr1", overrun_o,  1'b0);
    send_word(4'h5, 1'b0);
    chk("bp_par2", parallel_o, 4'hA);
    chk("bp_vld2", valid_o,    1'b1);
    chk("bp_ovr2", overrun_o,  1'b1);
    ready_i = 1'b1;
    cyc(1'b0, 1'b0);
    chk("bp_vld_drop", valid_o,   1'b0);
    chk("bp_ovr_stky", overrun_o, 1'b1);

    // Reset mid-frame, then 1,1,1,1 -> F
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    reset = 1'b1;
    cyc(1'b0, 1'b0);
    chk("mrst_par",  parallel_o, 4'h0);
    chk("mrst_vld",  valid_o,    1'b0);
    chk("mrst_busy", busy_o,     1'b0);
    chk("mrst_ovr",  overrun_o,  1'b0);
    reset = 1'b0;
    send_word(4'hF, 1'b1);
    chk("mrst_word", parallel_o, 4'hF);
    chk("mrst_wvld", valid_o,    1'b1);
    cyc(1'b0, 1'b0);

    // Accept and complete on the same edge: 3 held, C lands without overrun
    ready_i = 1'b0;
    send_word(4'h3, 1'b0);
    chk("sim_par1", parallel_o, 4'h3);
    send_word(4'hC, 1'b1);
    chk("sim_par2", parallel_o, 4'hC);
    chk("sim_vld",  valid_o,    1'b1);
    chk("sim_ovr",  overrun_o,  1'b0);
    cyc(1'b0, 1'b0);
    chk("sim_vld_drop", valid_o, 1'b0);

    // Back-to-back frames with no idle cycle
    send_word(4'h9, 1'b1);
    chk("b2b_par1", parallel_o, 4'h9);
    send_word(4'h4, 1'b1);
    chk("b2b_par2", parallel_o, 4'h4);
    chk("b2b_ovr",  overrun_o,  1'b0);
    cyc(1'b0, 1'b0);

`ifdef SIPO_PARITY_CHECK_EN
    // 7 with correct parity loads; with wrong parity drops and pulses the error
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    chk("par_busy", busy_o, 1'b1);
    cyc(1'b1, 1'b1);
    chk("par_ok_par",  parallel_o,   4'h7);
    chk("par_ok_vld",  valid_o,      1'b1);
    chk("par_ok_perr", parity_err_o, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("par_bad_perr", parity_err_o, 1'b1);
    chk("par_bad_vld",  valid_o,      1'b0);
    chk("par_bad_busy", busy_o,       1'b0);
    cyc(1'b0, 1'b0);
    chk("par_bad_pulse", parity_err_o, 1'b0);
`else
    chk("noparity_perr", parity_err_o, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
